apb_stdout_fifo: RTL and testbench

//  Synthesizable APB stdout sink at 0x1A10_3000 on the SoC peripheral APB bus (ADDR_END 0x1A10_3FFF).

---
 rtl/apb_stdout_fifo_if.sv | 24 ++
 rtl/apb_stdout_fifo.sv | 167 ++++++++++++++++
 tb/tb_apb_stdout_fifo.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/apb_stdout_fifo_if.sv
// rtl/apb_stdout_fifo_if.sv - APB bus interface with slave and master views
interface APB_BUS #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic                  pwrite;
  logic                  psel;
  logic                  penable;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport Slave (
    input  paddr, pwdata, pwrite, psel, penable,
    output prdata, pready, pslverr
  );

  modport Master (
    output paddr, pwdata, pwrite, psel, penable,
    input  prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_stdout_fifo.sv
// rtl/apb_stdout_fifo.sv - APB stdout character FIFO with pop register and threshold irq
// Optional overflow counter at 0x810 enabled by APB_STDOUT_FIFO_OVF_CNT_EN.
module apb_stdout_fifo #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int N_CORES    = 8,
  parameter int N_CLUSTERS = 1
) (
  input  logic  clk_i,
  input  logic  rst_i,
  APB_BUS.Slave apb,
  output logic  irq_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [11:0] A_STATUS = 12'h800;
  localparam logic [11:0] A_POP    = 12'h804;
  localparam logic [11:0] A_CTRL   = 12'h808;
  localparam logic [11:0] A_CLEAR  = 12'h80C;
  localparam logic [11:0] A_OVF    = 12'h810;

  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_ovf;
  logic          r_irq_en;
  logic [7:0]    r_thr;
  logic          r_irq;

  logic [11:0]   w_off;
  logic          w_access;
  logic          w_src_ok;
  logic          w_empty;
  logic          w_full;
  logic          w_err;
  logic [31:0]   w_rdata;
  logic          w_push_sel;
  logic          w_pop_sel;
  logic          w_ctrl_wr;
  logic          w_clear_wr;
  logic          w_do_push;
  logic          w_do_drop;
  logic          w_do_pop;
  logic          w_flush;
  logic          w_clr_ovf;
  logic [LW-1:0] w_level_nxt;
  logic          w_en_nxt;
  logic [7:0]    w_thr_nxt;
  logic [31:0]   w_status;

  assign w_off    = apb.paddr[11:0];
  assign w_access = apb.psel & apb.penable;
  assign w_src_ok = ({1'b0, w_off[10:7]} < 5'(N_CLUSTERS)) &&
                    ({1'b0, w_off[6:3]}  < 5'(N_CORES));
  assign w_empty  = (r_level == '0);
  assign w_full   = (r_level == LW'(DEPTH));
  assign w_status = {13'd0, r_ovf, w_full, w_empty, 16'(r_level)};

`ifdef APB_STDOUT_FIFO_OVF_CNT_EN
  logic [15:0] r_ovf_cnt;
`endif

  always_comb begin
    w_err      = 1'b0;
    w_rdata    = '0;
    w_push_sel = 1'b0;
    w_pop_sel  = 1'b0;
    w_ctrl_wr  = 1'b0;
    w_clear_wr = 1'b0;
    if (!w_off[11]) begin
      if (apb.pwrite && w_src_ok) w_push_sel = 1'b1;
      else                        w_err      = 1'b1;
    end else begin
      case (w_off)
        A_STATUS: begin
          if (apb.pwrite) w_err   = 1'b1;
          else            w_rdata = w_status;
        end
        A_POP: begin
          if (apb.pwrite) w_err = 1'b1;
          else begin
            w_pop_sel = 1'b1;
            if (!w_empty) w_rdata = {1'b1, 15'd0, r_mem[r_rd_ptr]};
          end
        end
        A_CTRL: begin
          if (apb.pwrite) w_ctrl_wr = 1'b1;
          else            w_rdata   = {16'd0, r_thr, 7'd0, r_irq_en};
        end
        A_CLEAR: begin
          if (apb.pwrite) w_clear_wr = 1'b1;
          else            w_err      = 1'b1;
        end
`ifdef APB_STDOUT_FIFO_OVF_CNT_EN
        A_OVF: begin
          if (apb.pwrite) w_err   = 1'b1;
          else            w_rdata = {16'd0, r_ovf_cnt};
        end
`endif
        default: w_err = 1'b1;
      endcase
    end
  end

  assign apb.pready  = apb.psel;
  assign apb.pslverr = w_access & w_err;
  assign apb.prdata  = w_access ? w_rdata : '0;

  assign w_do_push = w_access & w_push_sel & ~w_full;
  assign w_do_drop = w_access & w_push_sel &  w_full;
  assign w_do_pop  = w_access & w_pop_sel  & ~w_empty;
  assign w_flush   = w_access & w_clear_wr & apb.pwdata[0];
  assign w_clr_ovf = w_access & w_clear_wr & apb.pwdata[1];

  // irq follows the post-access state so it changes in the cycle right after the access.
  always_comb begin
    w_level_nxt = r_level;
    if (w_flush)        w_level_nxt = '0;
    else if (w_do_push) w_level_nxt = r_level + LW'(1);
    else if (w_do_pop)  w_level_nxt = r_level - LW'(1);
    w_en_nxt  = (w_access & w_ctrl_wr) ? apb.pwdata[0]    : r_irq_en;
    w_thr_nxt = (w_access & w_ctrl_wr) ? apb.pwdata[15:8] : r_thr;
  end

  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wr_ptr] <= {w_off[10:3], apb.pwdata[7:0]};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ovf    <= 1'b0;
      r_irq_en <= 1'b0;
      r_thr    <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_level  <= w_level_nxt;
      r_irq_en <= w_en_nxt;
      r_thr    <= w_thr_nxt;
      r_irq    <= w_en_nxt && (w_thr_nxt != '0) && (16'(w_level_nxt) >= 16'(w_thr_nxt));
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_clr_ovf)      r_ovf <= 1'b0;
      else if (w_do_drop) r_ovf <= 1'b1;
    end
  end

`ifdef APB_STDOUT_FIFO_OVF_CNT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                r_ovf_cnt <= '0;
    else if (w_clr_ovf)                       r_ovf_cnt <= '0;
    else if (w_do_drop && r_ovf_cnt != '1)    r_ovf_cnt <= r_ovf_cnt + 16'd1;
  end
`endif

  assign irq_o = r_irq;
endmodule

// File: tb/tb_apb_stdout_fifo.sv
// tb/tb_apb_stdout_fifo.sv - scoreboard bench for apb_stdout_fifo
module tb_apb_stdout_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq;
  int   n_checks = 0;
  int   n_errors = 0;

  typedef struct {
    logic [31:0] data;
    bit          chk_data;
    logic        err;
    string       name;
  } exp_t;
  exp_t exp_q[$];

  APB_BUS #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  apb_stdout_fifo #(.DEPTH(64), .N_CORES(8), .N_CLUSTERS(1)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .apb   (bus),
    .irq_o (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: every access phase pops one expectation and compares.
  always @(negedge clk) begin
    if (bus.psel && bus.penable) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, "_pready"}, {31'd0, bus.pready}, 32'd1);
        check({e.name, "_pslverr"}, {31'd0, bus.pslverr}, {31'd0, e.err});
        if (e.chk_data) check({e.name, "_prdata"}, bus.prdata, e.data);
      end
    end
  end

  task automatic apb(input logic [31:0] addr, input logic [31:0] wd, input bit wr,
                     input logic [31:0] ed, input bit chk, input logic ee, input string nm);
    exp_t e;
    @(posedge clk); #1;
    bus.paddr = addr; bus.pwdata = wd; bus.pwrite = wr; bus.psel = 1'b1; bus.penable = 1'b0;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    e.data = ed; e.chk_data = chk; e.err = ee; e.name = nm;
    exp_q.push_back(e);
    @(posedge clk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic ee, input string nm);
    apb(a, d, 1'b1, 32'd0, 1'b0, ee, nm);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] ed, input logic ee, input string nm);
    apb(a, 32'd0, 1'b0, ed, 1'b1, ee, nm);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.paddr = '0; bus.pwdata = '0; bus.pwrite = 1'b0; bus.psel = 1'b0; bus.penable = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("reset_irq", {31'd0, irq}, 32'd0);
    rst = 1'b0;
    rd(32'h800, 32'h0001_0000, 1'b0, "reset_status");
    rd(32'h808, 32'h0000_0000, 1'b0, "reset_ctrl");

    // Single char round trip: cluster0 core1 -> src 0x01.
    wr(32'h008, 32'h41, 1'b0, "t1_putc");
    rd(32'h804, 32'h8000_0141, 1'b0, "t1_pop");
    rd(32'h800, 32'h0001_0000, 1'b0, "t1_status");

    // Fill to full plus one overflow, then drain in order.
    for (int i = 0; i < 64; i++) wr(32'((i % 8) << 3), 32'(i), 1'b0, "t2_fill");
    wr(32'h000, 32'hFF, 1'b0, "t2_overflow");
    rd(32'h800, 32'h0006_0040, 1'b0, "t2_status_full");
    for (int i = 0; i < 64; i++)
      rd(32'h804, 32'h8000_0000 | 32'((i % 8) << 8) | 32'(i), 1'b0, "t2_pop");
    rd(32'h800, 32'h0005_0000, 1'b0, "t2_status_drained");
    rd(32'h804, 32'h0000_0000, 1'b0, "t2_pop_empty");
    wr(32'h80C, 32'h2, 1'b0, "t2_clear_ovf");
    rd(32'h800, 32'h0001_0000, 1'b0, "t2_status_clr");

    // Threshold interrupt.
    wr(32'h808, 32'h0000_0401, 1'b0, "t3_ctrl");
    rd(32'h808, 32'h0000_0401, 1'b0, "t3_ctrl_rd");
    for (int k = 0; k < 3; k++) begin
      wr(32'h010, 32'(8'h30 + k), 1'b0, "t3_putc");
      check("t3_irq_below", {31'd0, irq}, 32'd0);
    end
    wr(32'h010, 32'h33, 1'b0, "t3_putc4");
    check("t3_irq_at_thr", {31'd0, irq}, 32'd1);
    rd(32'h804, 32'h8000_0230, 1'b0, "t3_pop");
    check("t3_irq_after_pop", {31'd0, irq}, 32'd0);
    wr(32'h808, 32'h0000_0001, 1'b0, "t3_ctrl_thr0");
    check("t3_irq_thr0", {31'd0, irq}, 32'd0);
    wr(32'h808, 32'hFFFF_FF01, 1'b0, "t3_ctrl_bits");
    rd(32'h808, 32'h0000_FF01, 1'b0, "t3_ctrl_mask");
    check("t3_irq_thr_big", {31'd0, irq}, 32'd0);
    wr(32'h80C, 32'h1, 1'b0, "t3_flush");
    wr(32'h808, 32'h0, 1'b0, "t3_ctrl_off");
    rd(32'h800, 32'h0001_0000, 1'b0, "t3_status");

    // Flush and clear-ovf together.
    for (int i = 0; i < 10; i++) wr(32'h018, 32'(i), 1'b0, "t4_fill");
    rd(32'h800, 32'h0000_000A, 1'b0, "t4_status10");
    wr(32'h80C, 32'h3, 1'b0, "t4_clear");
    rd(32'h800, 32'h0001_0000, 1'b0, "t4_status");
    rd(32'h804, 32'h0000_0000, 1'b0, "t4_pop_empty");

    // Decode errors.
    wr(32'h088, 32'h11, 1'b1, "t5_cluster1");
    wr(32'h100, 32'h22, 1'b1, "t5_cluster2");
    wr(32'h040, 32'h33, 1'b1, "t5_core8");
    rd(32'h800, 32'h0001_0000, 1'b0, "t5_status");
    wr(32'h900, 32'h1, 1'b1, "t5_unmapped_wr");
    rd(32'h900, 32'h0, 1'b1, "t5_unmapped_rd");
    wr(32'h800, 32'h1, 1'b1, "t5_wr_status");
    rd(32'h80C, 32'h0, 1'b1, "t5_rd_clear");
    rd(32'h008, 32'h0, 1'b1, "t5_rd_putc");
    wr(32'h1A10_3008, 32'h5A, 1'b0, "t5_full_addr");
    rd(32'h1A10_3804, 32'h8000_015A, 1'b0, "t5_pop_full_addr");

`ifdef APB_STDOUT_FIFO_OVF_CNT_EN
    for (int i = 0; i < 67; i++) wr(32'h008, 32'(i), 1'b0, "t7_fill");
    rd(32'h810, 32'h0000_0003, 1'b0, "t7_ovf_cnt");
    wr(32'h80C, 32'h2, 1'b0, "t7_clear_ovf");
    rd(32'h810, 32'h0000_0000, 1'b0, "t7_ovf_cnt_clr");
    wr(32'h80C, 32'h1, 1'b0, "t7_flush");
`else
    rd(32'h810, 32'h0, 1'b1, "t7_ovf_cnt_absent");
`endif

    // Reset in the middle of a transfer with a populated FIFO.
    wr(32'h808, 32'h0000_0401, 1'b0, "t6_ctrl");
    for (int i = 0; i < 5; i++) wr(32'h008, 32'(i), 1'b0, "t6_fill");
    check("t6_irq_pre", {31'd0, irq}, 32'd1);
    @(posedge clk); #1;
    bus.paddr = 32'h008; bus.pwdata = 32'h77; bus.pwrite = 1'b1; bus.psel = 1'b1; bus.penable = 1'b0;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    begin
      exp_t e;
      e.data = 32'd0; e.chk_data = 1'b0; e.err = 1'b0; e.name = "t6_aborted";
      exp_q.push_back(e);
    end
    #1 rst = 1'b1;
    #1 check("t6_irq_rst", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0;
    rd(32'h800, 32'h0001_0000, 1'b0, "t6_status_in_rst");
    rd(32'h808, 32'h0000_0000, 1'b0, "t6_ctrl_in_rst");
    rst = 1'b0;
    rd(32'h800, 32'h0001_0000, 1'b0, "t6_status_after");

    repeat (2) @(posedge clk);
    #1 check("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
